// File: rtl/field_compositor.sv
// Field compositor: searches the ghost landing row one candidate per cycle, then
// renders settled field + active piece + ghost into a registered snapshot, one row per cycle.
`ifndef FIELD_HORIZONTAL
`define FIELD_HORIZONTAL 10
`endif
`ifndef FIELD_VERTICAL
`define FIELD_VERTICAL 20
`endif

package tetris_pkg;
    typedef struct packed {
        logic [3:0][3:0][3:0] data;   // [rotation][mask row i][mask col j]
    } tetromino_t;

    typedef struct packed {
        logic signed [7:0] x;
        logic signed [7:0] y;
    } coord_t;

    typedef struct packed {
        tetromino_t tetromino;
        logic [1:0] rotation;
        coord_t     coordinate;
        logic [3:0] idx;
    } tetromino_ctrl;
endpackage

module field_compositor
    import tetris_pkg::*;
#(
    parameter int                    FIELD_W   = `FIELD_HORIZONTAL,
    parameter int                    FIELD_H   = `FIELD_VERTICAL,
    parameter int                    CELL_BITS = 4,
    parameter logic [CELL_BITS-1:0]  GHOST_IDX = {CELL_BITS{1'b1}}
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          ghost_en,
    input  tetromino_ctrl                                 t_ctrl,
    input  logic [FIELD_H-1:0][FIELD_W-1:0][CELL_BITS-1:0] f_in,
    output logic                                          busy,
    output logic                                          done,
    output logic [FIELD_H-1:0][FIELD_W-1:0][CELL_BITS-1:0] f_out,
    output logic signed [$clog2(FIELD_H)+2:0]             ghost_y,
    output logic                                          overlap
);

    localparam int GY_W = $clog2(FIELD_H) + 3;
    localparam int YW   = $clog2(FIELD_H);
    localparam int XW   = $clog2(FIELD_W);

    typedef logic [FIELD_H-1:0][FIELD_W-1:0][CELL_BITS-1:0] field_t;
    typedef logic [FIELD_W-1:0][CELL_BITS-1:0]              row_t;
    typedef logic [3:0][3:0]                                mask_t;
    typedef logic signed [15:0]                             pos_t;

    typedef enum logic [1:0] {IDLE, GHOST, ROWS, DONE} state_t;

    state_t               state_q, state_d;
    logic [YW-1:0]        row_q, row_d;
    pos_t                 cand_q, cand_d;
    pos_t                 gy_q, gy_d;
    logic                 overlap_q, overlap_d;
    logic                 gdraw_q, gdraw_d;
    field_t               f_out_q, f_out_d;
    field_t               f_q, f_d;
    mask_t                mask_q, mask_d;
    pos_t                 cx_q, cx_d;
    pos_t                 cy_q, cy_d;
    logic [CELL_BITS-1:0] idx_q, idx_d;
    logic                 hit;
    row_t                 new_row;

    // Walls and floor always collide; cells above the top only collide with the side walls.
    function automatic logic collide(input mask_t m, input pos_t ox, input pos_t oy,
                                     input field_t fld);
        logic h;
        int   x;
        int   y;
        h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (m[i][j]) begin
                    x = int'(ox) + j;
                    y = int'(oy) + i;
                    if (x < 0 || x >= FIELD_W || y >= FIELD_H)
                        h = 1'b1;
                    else if (y >= 0 && fld[YW'(y)][XW'(x)] != '0)
                        h = 1'b1;
                end
            end
        end
        return h;
    endfunction

    function automatic logic piece_at(input mask_t m, input pos_t ox, input pos_t oy,
                                      input int r, input int c);
        int dr;
        int dc;
        dr = r - int'(oy);
        dc = c - int'(ox);
        if (dr < 0 || dr > 3 || dc < 0 || dc > 3)
            return 1'b0;
        return m[2'(dr)][2'(dc)];
    endfunction

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cand_d    = cand_q;
        gy_d      = gy_q;
        overlap_d = overlap_q;
        gdraw_d   = gdraw_q;
        f_out_d   = f_out_q;
        f_d       = f_q;
        mask_d    = mask_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        idx_d     = idx_q;
        hit       = 1'b0;
        new_row   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    f_d       = f_in;
                    mask_d    = t_ctrl.tetromino.data[t_ctrl.rotation];
                    cx_d      = pos_t'(t_ctrl.coordinate.x);
                    cy_d      = pos_t'(t_ctrl.coordinate.y);
                    idx_d     = CELL_BITS'(t_ctrl.idx);
                    hit       = collide(mask_d, cx_d, cy_d, f_in);
                    overlap_d = hit;
                    cand_d    = cy_d;
                    gy_d      = cy_d;
                    row_d     = '0;
                    gdraw_d   = ghost_en && !hit;
                    state_d   = (ghost_en && !hit) ? GHOST : ROWS;
                end
            end
            GHOST: begin
                hit = collide(mask_q, cx_q, cand_q + 16'sd1, f_q);
                if (hit) begin
                    gy_d    = cand_q;
                    row_d   = '0;
                    state_d = ROWS;
                end else begin
                    cand_d = cand_q + 16'sd1;
                end
            end
            ROWS: begin
                // Active piece wins over ghost, ghost wins over settled field.
                for (int c = 0; c < FIELD_W; c++) begin
                    if (piece_at(mask_q, cx_q, cy_q, int'(row_q), c))
                        new_row[XW'(c)] = idx_q;
                    else if (gdraw_q && piece_at(mask_q, cx_q, gy_q, int'(row_q), c))
                        new_row[XW'(c)] = GHOST_IDX;
                    else
                        new_row[XW'(c)] = f_q[row_q][XW'(c)];
                end
                f_out_d[row_q] = new_row;
                row_d          = row_q + 1'b1;
                if (row_q == YW'(FIELD_H - 1)) begin
                    row_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            cand_q    <= '0;
            gy_q      <= '0;
            overlap_q <= 1'b0;
            gdraw_q   <= 1'b0;
            f_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cand_q    <= cand_d;
            gy_q      <= gy_d;
            overlap_q <= overlap_d;
            gdraw_q   <= gdraw_d;
            f_out_q   <= f_out_d;
        end
    end

    // Request snapshot: only meaningful after a start, so it needs no reset.
    always_ff @(posedge clk) begin
        f_q    <= f_d;
        mask_q <= mask_d;
        cx_q   <= cx_d;
        cy_q   <= cy_d;
        idx_q  <= idx_d;
    end

    assign busy    = (state_q == GHOST) || (state_q == ROWS);
    assign done    = (state_q == DONE);
    assign f_out   = f_out_q;
    assign ghost_y = gy_q[GY_W-1:0];
    assign overlap = overlap_q;

endmodule

// File: tb/tb_field_compositor.sv
// Directed bench for field_compositor on a 10x20 field with hand-computed snapshots.
`timescale 1ns/1ps
module tb_field_compositor;
    import tetris_pkg::*;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int CB = 4;

    typedef logic [H-1:0][W-1:0][CB-1:0] field_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               ghost_en;
    tetromino_ctrl      t_ctrl;
    field_t             f_in;
    field_t             f_out;
    logic               busy;
    logic               done;
    logic               overlap;
    logic signed [7:0]  ghost_y;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    field_compositor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ghost_en(ghost_en),
        .t_ctrl  (t_ctrl),
        .f_in    (f_in),
        .busy    (busy),
        .done    (done),
        .f_out   (f_out),
        .ghost_y (ghost_y),
        .overlap (overlap)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // 2x2 block in mask rows 0-1, cols 1-2 of rotation 0; other rotations hold decoys.
    function automatic tetromino_ctrl square_piece(input logic signed [7:0] x,
                                                   input logic signed [7:0] y,
                                                   input logic [3:0] id);
        tetromino_ctrl t;
        t = '0;
        t.tetromino.data[0][0][1] = 1'b1;
        t.tetromino.data[0][0][2] = 1'b1;
        t.tetromino.data[0][1][1] = 1'b1;
        t.tetromino.data[0][1][2] = 1'b1;
        t.tetromino.data[1][3]    = 4'hF;
        t.tetromino.data[2][2][0] = 1'b1;
        t.rotation     = 2'd0;
        t.coordinate.x = x;
        t.coordinate.y = y;
        t.idx          = id;
        return t;
    endfunction

    // I-piece horizontal in mask row 1 of rotation 1; rotation 0 holds a decoy.
    function automatic tetromino_ctrl i_piece(input logic signed [7:0] x,
                                              input logic signed [7:0] y,
                                              input logic [3:0] id);
        tetromino_ctrl t;
        t = '0;
        t.tetromino.data[1][1]    = 4'hF;
        t.tetromino.data[0][3][3] = 1'b1;
        t.rotation     = 2'd1;
        t.coordinate.x = x;
        t.coordinate.y = y;
        t.idx          = id;
        return t;
    endfunction

    function automatic int first_diff(input field_t a, input field_t b);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (a[5'(r)][4'(c)] !== b[5'(r)][4'(c)])
                    return r * W + c;
        return -1;
    endfunction

    // Issues one request, scrambles the inputs after the start edge, and counts the
    // cycle in which done is seen (cycle 1 is the one right after the start edge).
    task automatic run_snap(input logic ge, input tetromino_ctrl tc, input field_t fld,
                            output int lat);
        @(negedge clk);
        t_ctrl   = tc;
        f_in     = fld;
        ghost_en = ge;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
        f_in           = ~fld;
        ghost_en       = ~ge;
        t_ctrl.coordinate.x = tc.coordinate.x + 8'sd2;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        ghost_en = 1'b0;
        t_ctrl   = '0;
        f_in     = '0;
        #23;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
        n_total++; if (overlap !== 1'b0) $display("FAIL reset_overlap got %0b want 0", overlap); else n_pass++;
        n_total++; if (ghost_y !== 8'sd0) $display("FAIL reset_ghost_y got %0d want 0", ghost_y); else n_pass++;
        n_total++; if (f_out !== '0) $display("FAIL reset_f_out got nonzero want 0"); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_empty_ghost();
        field_t exp;
        int lat, d;
        run_snap(1'b1, square_piece(8'sd4, 8'sd0, 4'd3), '0, lat);
        exp = '0;
        exp[0][5] = 4'd3;  exp[0][6] = 4'd3;  exp[1][5] = 4'd3;  exp[1][6] = 4'd3;
        exp[18][5] = 4'hF; exp[18][6] = 4'hF; exp[19][5] = 4'hF; exp[19][6] = 4'hF;
        n_total++; if (lat !== 40) $display("FAIL empty_latency got %0d want 40", lat); else n_pass++;
        n_total++; if (ghost_y !== 8'sd18) $display("FAIL empty_ghost_y got %0d want 18", ghost_y); else n_pass++;
        n_total++; if (overlap !== 1'b0) $display("FAIL empty_overlap got %0b want 0", overlap); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL empty_busy_at_done got %0b want 0", busy); else n_pass++;
        n_total++;
        if (f_out !== exp) begin
            d = first_diff(f_out, exp);
            $display("FAIL empty_image first bad cell %0d got %0d want %0d", d,
                     f_out[5'(d / W)][4'(d % W)], exp[5'(d / W)][4'(d % W)]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_ghost();
        field_t exp;
        int lat, d, seen;
        @(negedge clk);
        t_ctrl   = square_piece(8'sd4, 8'sd0, 4'd3);
        f_in     = '0;
        ghost_en = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got %0b want 1", busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (f_out !== '0) $display("FAIL midrst_f_out got nonzero want 0"); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (ghost_y !== 8'sd0) $display("FAIL midrst_ghost_y got %0d want 0", ghost_y); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL midrst_no_done got %0d active cycles want 0", seen); else n_pass++;
        run_snap(1'b1, square_piece(8'sd4, 8'sd0, 4'd3), '0, lat);
        exp = '0;
        exp[0][5] = 4'd3;  exp[0][6] = 4'd3;  exp[1][5] = 4'd3;  exp[1][6] = 4'd3;
        exp[18][5] = 4'hF; exp[18][6] = 4'hF; exp[19][5] = 4'hF; exp[19][6] = 4'hF;
        n_total++; if (lat !== 40) $display("FAIL midrst_rerun_latency got %0d want 40", lat); else n_pass++;
        n_total++;
        if (f_out !== exp) begin
            d = first_diff(f_out, exp);
            $display("FAIL midrst_rerun_image first bad cell %0d got %0d want %0d", d,
                     f_out[5'(d / W)][4'(d % W)], exp[5'(d / W)][4'(d % W)]);
        end else n_pass++;
    endtask

    task automatic test_floor();
        field_t fld, exp;
        int lat, d;
        fld = '0;
        for (int c = 0; c < W; c++) fld[10][4'(c)] = 4'd1;
        run_snap(1'b1, square_piece(8'sd4, 8'sd0, 4'd3), fld, lat);
        exp = fld;
        exp[0][5] = 4'd3; exp[0][6] = 4'd3; exp[1][5] = 4'd3; exp[1][6] = 4'd3;
        exp[8][5] = 4'hF; exp[8][6] = 4'hF; exp[9][5] = 4'hF; exp[9][6] = 4'hF;
        n_total++; if (lat !== 30) $display("FAIL floor_latency got %0d want 30", lat); else n_pass++;
        n_total++; if (ghost_y !== 8'sd8) $display("FAIL floor_ghost_y got %0d want 8", ghost_y); else n_pass++;
        n_total++;
        if (f_out !== exp) begin
            d = first_diff(f_out, exp);
            $display("FAIL floor_image first bad cell %0d got %0d want %0d", d,
                     f_out[5'(d / W)][4'(d % W)], exp[5'(d / W)][4'(d % W)]);
        end else n_pass++;
    endtask

    task automatic test_spawn_overlap();
        field_t fld, exp;
        int lat, d;
        fld = '0;
        fld[0][5] = 4'd2;
        run_snap(1'b1, square_piece(8'sd4, 8'sd0, 4'd3), fld, lat);
        exp = '0;
        exp[0][5] = 4'd3; exp[0][6] = 4'd3; exp[1][5] = 4'd3; exp[1][6] = 4'd3;
        n_total++; if (lat !== 21) $display("FAIL spawn_latency got %0d want 21", lat); else n_pass++;
        n_total++; if (overlap !== 1'b1) $display("FAIL spawn_overlap got %0b want 1", overlap); else n_pass++;
        n_total++; if (ghost_y !== 8'sd0) $display("FAIL spawn_ghost_y got %0d want 0", ghost_y); else n_pass++;
        n_total++; if (f_out[0][5] !== 4'd3) $display("FAIL spawn_cell_0_5 got %0d want 3", f_out[0][5]); else n_pass++;
        n_total++;
        if (f_out !== exp) begin
            d = first_diff(f_out, exp);
            $display("FAIL spawn_image first bad cell %0d got %0d want %0d", d,
                     f_out[5'(d / W)][4'(d % W)], exp[5'(d / W)][4'(d % W)]);
        end else n_pass++;
    endtask

    task automatic test_wall_clip();
        field_t exp;
        int lat, d;
        run_snap(1'b0, i_piece(-8'sd1, 8'sd5, 4'd5), '0, lat);
        exp = '0;
        exp[6][0] = 4'd5; exp[6][1] = 4'd5; exp[6][2] = 4'd5;
        n_total++; if (lat !== 21) $display("FAIL wall_latency got %0d want 21", lat); else n_pass++;
        n_total++; if (overlap !== 1'b1) $display("FAIL wall_overlap got %0b want 1", overlap); else n_pass++;
        n_total++; if (ghost_y !== 8'sd5) $display("FAIL wall_ghost_y got %0d want 5", ghost_y); else n_pass++;
        n_total++; if (f_out[6][9] !== 4'd0) $display("FAIL wall_no_wrap got %0d want 0", f_out[6][9]); else n_pass++;
        n_total++;
        if (f_out !== exp) begin
            d = first_diff(f_out, exp);
            $display("FAIL wall_image first bad cell %0d got %0d want %0d", d,
                     f_out[5'(d / W)][4'(d % W)], exp[5'(d / W)][4'(d % W)]);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        field_t exp;
        int lat, d, seen;
        @(negedge clk);
        t_ctrl   = square_piece(8'sd4, 8'sd0, 4'd3);
        f_in     = '0;
        ghost_en = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (n == 3) begin
                t_ctrl   = square_piece(8'sd0, 8'sd5, 4'd7);
                ghost_en = 1'b0;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        // Request presented during the done cycle.
        t_ctrl   = i_piece(8'sd3, 8'sd12, 4'd9);
        ghost_en = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_after_done_start got %0b want 0", busy); else n_pass++;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        exp = '0;
        exp[0][5] = 4'd3;  exp[0][6] = 4'd3;  exp[1][5] = 4'd3;  exp[1][6] = 4'd3;
        exp[18][5] = 4'hF; exp[18][6] = 4'hF; exp[19][5] = 4'hF; exp[19][6] = 4'hF;
        n_total++; if (lat !== 40) $display("FAIL b2b_latency got %0d want 40", lat); else n_pass++;
        n_total++; if (seen !== 0) $display("FAIL b2b_ignored got %0d active cycles want 0", seen); else n_pass++;
        n_total++; if (ghost_y !== 8'sd18) $display("FAIL b2b_ghost_y got %0d want 18", ghost_y); else n_pass++;
        n_total++;
        if (f_out !== exp) begin
            d = first_diff(f_out, exp);
            $display("FAIL b2b_image first bad cell %0d got %0d want %0d", d,
                     f_out[5'(d / W)][4'(d % W)], exp[5'(d / W)][4'(d % W)]);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_empty_ghost();
        test_reset_mid_ghost();
        test_floor();
        test_spawn_overlap();
        test_wall_clip();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/field_compositor.md
# field_compositor

Sequential, parametrised field compositor. It renders the settled playfield, the active tetromino and an optional ghost piece (landing preview) into a registered display snapshot. The block computes the ghost landing row by stepping down one candidate row per cycle, composes the output one row per cycle, and reports spawn overlap. It sits between the game-logic FSM, which owns the settled field and `tetromino_ctrl`, and the VGA/draw path. The draw path consumes `f_out` after `done`.

## Interface
Parameters:
- `FIELD_W`, default `` `FIELD_HORIZONTAL ``: field columns.
- `FIELD_H`, default `` `FIELD_VERTICAL ``: field rows.
- `CELL_BITS`, default 4: bits per cell. Value 0 means empty.
- `GHOST_IDX`, default `{CELL_BITS{1'b1}}`: cell code written for ghost cells.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new snapshot. Sampled only in IDLE.
- `ghost_en`  in  1  enable ghost computation and drawing. Sampled with `start`.
- `t_ctrl`  in  `tetromino_ctrl`  active piece: `tetromino.data[rot][i][j]` mask, `rotation`, signed `coordinate.x/y`, `idx`. Sampled with `start`.
- `f_in`  in  `[FIELD_H][FIELD_W][CELL_BITS]`  settled field. Sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is asserted.
- `done`  out  1  one-cycle pulse when `f_out` is complete.
- `f_out`  out  `[FIELD_H][FIELD_W][CELL_BITS]`  composited snapshot. Held stable between `done` and the next accepted `start`.
- `ghost_y`  out  signed `$clog2(FIELD_H)+3`  landing row of the piece origin. Valid with `done`.
- `overlap`  out  1  the active piece collides at its current position. Valid with `done`.

## Operation
- Piece cell (i,j) is a mask bit at `data[rot][i][j]`. Its absolute position is x = cx+j, y = cy+i, evaluated in signed arithmetic.
- `collide(y')` is true if any mask cell at origin (cx, y') satisfies at least one of:
  - x<0
  - x>=FIELD_W
  - y>=FIELD_H
  - 0<=y and `f_in_latched[y][x]!=0`
- Cells with y<0 and x in range never collide.
- FSM states: IDLE, GHOST, ROWS, DONE.
- IDLE, when `start`=1:
  - Latch `t_ctrl`, `f_in` and `ghost_en`.
  - Register `overlap` = `collide(cy)` and set `cand` = cy.
  - If overlap=1 or ghost_en=0: set `ghost_y` = cy, skip ghost drawing, set row=0 and go to ROWS.
  - Otherwise go to GHOST.
- GHOST: each cycle evaluates `collide(cand+1)`.
  - If true: `ghost_y` = cand, row=0, go to ROWS.
  - If false: cand++.
  - The bottom wall guarantees exit within FIELD_H+4 cycles.
- ROWS: each cycle writes `f_out[row][*]`, then row++. After row FIELD_H-1, go to DONE. Per cell, first match wins:
  - active piece cell → `idx`
  - ghost piece cell (origin cx, ghost_y; ghost enabled and not overlap) → `GHOST_IDX`
  - otherwise `f_in_latched` value.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- Piece and ghost cells outside the field are not drawn, and never wrap.
- `start` while busy is ignored, with no queuing.
- A `start` in the same cycle as `done` is also ignored, because the FSM is in DONE, not IDLE.
- Rows of `f_out` not yet rewritten keep their previous-snapshot values during ROWS. Consumers use only the post-`done` image.

## Timing
- Reset (async, `rst_n`=0): FSM→IDLE; `busy`=0, `done`=0, `overlap`=0, `ghost_y`=0, `f_out`=all zero, cand/row=0.
  - Reset mid-operation aborts immediately and no `done` is issued.
  - Deassertion is synchronous to `clk` via the standard reset synchroniser upstream.
- Latency from the `start` sampling edge to `done` high: 1 + (ghost_en && !overlap ? k+1 : 0) + FIELD_H cycles, where k = ghost_y − cy.
- `busy` rises the cycle after the start edge and falls with `done`.
- Minimum start-to-start spacing is latency+1.
- `overlap` and `ghost_y` update on the start edge or the GHOST exit edge, and are stable with `done`.

## Test plan
- Reset mid-GHOST: assert `rst_n`=0 asynchronously → `f_out`=0, `busy`=0, `done` never pulses; the next `start` completes normally.
- 10×20 field, empty; 2×2 mask in mask rows 0–1, cols 1–2; cx=4, cy=0; ghost_en=1; idx=3 →
  - `ghost_y`=18, `overlap`=0, `done` 40 cycles after the start edge;
  - rows 0–1 cols 5–6 = 3, rows 18–19 cols 5–6 = `GHOST_IDX`, all other cells = 0.
- Same piece, row 10 filled with 1, ghost_en=1 → `ghost_y`=8; rows 8–9 cols 5–6 ghost; row 10 unchanged.
- Spawn on an occupied cell (f_in[0][5]=2) → `overlap`=1, no ghost drawn, `f_out[0][5]`=idx, `done` 21 cycles after start.
- ghost_en=0, I-piece mask row 1 cols 0–3, cx=−1 → no ghost; cells at x=0..2 drawn, x=−1 dropped; `overlap`=1 (x<0); no wrap to column 9.
- `start` pulsed while busy and again in the `done` cycle → both ignored; `f_out` reflects only the first request.
